// File: rtl/wb_exc_seq.sv
// Exception / ERTN commit sequencer at WB: owns the CSR write port, walks the
// CSR update sequence one write per cycle and then issues a redirect to IF.
module wb_exc_seq #(
  parameter logic [13:0] CSR_CRMD  = 14'h000,
  parameter logic [13:0] CSR_PRMD  = 14'h001,
  parameter logic [13:0] CSR_ESTAT = 14'h005,
  parameter logic [13:0] CSR_ERA   = 14'h006,
  parameter logic [13:0] CSR_BADV  = 14'h007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic        wb_ertn,
  input  logic        wb_badv_we,
  input  logic [31:0] wb_badv,
  input  logic        wb_csr_we,
  input  logic [13:0] wb_csr_num,
  input  logic [31:0] wb_csr_wdata,
  input  logic [31:0] wb_csr_wmask,
  input  logic [31:0] csr_crmd,
  input  logic [31:0] csr_prmd,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wdata,
  output logic [31:0] csr_wmask,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        seq_ready_go,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRMD,
    S_CRMD,
    S_ESTAT,
    S_ERA,
    S_BADV,
    S_ERTN_CRMD,
    S_REDIR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] badv_q, badv_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esubcode_q, esubcode_d;
  logic        badv_we_q, badv_we_d;
  logic        is_ex_q, is_ex_d;
  logic        trigger;

  // Only the PLV/IE fields of CRMD and PRMD take part in the sequence.
  logic unused_ok;
  assign unused_ok = ^{csr_crmd[31:3], csr_prmd[31:3]};

  assign trigger = wb_valid & (wb_ex | wb_ertn);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      badv_q     <= '0;
      ecode_q    <= '0;
      esubcode_q <= '0;
      badv_we_q  <= 1'b0;
      is_ex_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      badv_q     <= badv_d;
      ecode_q    <= ecode_d;
      esubcode_q <= esubcode_d;
      badv_we_q  <= badv_we_d;
      is_ex_q    <= is_ex_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    badv_d         = badv_q;
    ecode_d        = ecode_q;
    esubcode_d     = esubcode_q;
    badv_we_d      = badv_we_q;
    is_ex_d        = is_ex_q;
    csr_we         = 1'b0;
    csr_num        = '0;
    csr_wdata      = '0;
    csr_wmask      = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    seq_ready_go   = 1'b0;
    busy           = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (trigger) begin
          // The excepting instruction's own CSR write is dropped here.
          flush      = 1'b1;
          pc_d       = wb_pc;
          badv_d     = wb_badv;
          ecode_d    = wb_ecode;
          esubcode_d = wb_esubcode;
          badv_we_d  = wb_badv_we;
          is_ex_d    = wb_ex;
          state_d    = wb_ex ? S_PRMD : S_ERTN_CRMD;
        end else begin
          seq_ready_go = 1'b1;
          csr_we       = wb_csr_we;
          csr_num      = wb_csr_num;
          csr_wdata    = wb_csr_wdata;
          csr_wmask    = wb_csr_wmask;
        end
      end
      S_PRMD: begin
        csr_we    = 1'b1;
        csr_num   = CSR_PRMD;
        csr_wdata = {29'b0, csr_crmd[2:0]};
        csr_wmask = 32'h0000_0007;
        state_d   = S_CRMD;
      end
      S_CRMD: begin
        csr_we    = 1'b1;
        csr_num   = CSR_CRMD;
        csr_wdata = 32'h0;
        csr_wmask = 32'h0000_0007;
        state_d   = S_ESTAT;
      end
      S_ESTAT: begin
        csr_we    = 1'b1;
        csr_num   = CSR_ESTAT;
        csr_wdata = {1'b0, esubcode_q, ecode_q, 16'b0};
        csr_wmask = 32'h7FFF_0000;
        state_d   = S_ERA;
      end
      S_ERA: begin
        csr_we    = 1'b1;
        csr_num   = CSR_ERA;
        csr_wdata = pc_q;
        csr_wmask = 32'hFFFF_FFFF;
        state_d   = badv_we_q ? S_BADV : S_REDIR;
      end
      S_BADV: begin
        csr_we    = 1'b1;
        csr_num   = CSR_BADV;
        csr_wdata = badv_q;
        csr_wmask = 32'hFFFF_FFFF;
        state_d   = S_REDIR;
      end
      S_ERTN_CRMD: begin
        csr_we    = 1'b1;
        csr_num   = CSR_CRMD;
        csr_wdata = {29'b0, csr_prmd[2:0]};
        csr_wmask = 32'h0000_0007;
        state_d   = S_REDIR;
      end
      S_REDIR: begin
        // ERA is read live so a value written in the ERA step is already visible.
        redirect_valid = 1'b1;
        redirect_pc    = is_ex_q ? csr_eentry : csr_era;
        seq_ready_go   = 1'b1;
        state_d        = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A reset cycle must never commit a CSR write, flush or redirect.
    if (reset) begin
      csr_we         = 1'b0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      seq_ready_go   = 1'b1;
      busy           = 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_exc_seq.sv
// Directed bench for wb_exc_seq: walks each commit sequence cycle by cycle and
// compares the CSR write port and control strobes against hand-computed values.
module tb_wb_exc_seq;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        wb_ertn;
  logic        wb_badv_we;
  logic [31:0] wb_badv;
  logic        wb_csr_we;
  logic [13:0] wb_csr_num;
  logic [31:0] wb_csr_wdata;
  logic [31:0] wb_csr_wmask;
  logic [31:0] csr_crmd;
  logic [31:0] csr_prmd;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wdata;
  logic [31:0] csr_wmask;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        seq_ready_go;
  logic        busy;

  int checks;
  int errors;

  // Observation bundles: {we, num, wdata, wmask} and {flush, redirect, ready_go, busy}.
  logic [78:0] csr_bus;
  logic [3:0]  ctl;
  assign csr_bus = {csr_we, csr_num, csr_wdata, csr_wmask};
  assign ctl     = {flush, redirect_valid, seq_ready_go, busy};

  wb_exc_seq dut (
    .clk            (clk),
    .reset          (reset),
    .wb_valid       (wb_valid),
    .wb_pc          (wb_pc),
    .wb_ex          (wb_ex),
    .wb_ecode       (wb_ecode),
    .wb_esubcode    (wb_esubcode),
    .wb_ertn        (wb_ertn),
    .wb_badv_we     (wb_badv_we),
    .wb_badv        (wb_badv),
    .wb_csr_we      (wb_csr_we),
    .wb_csr_num     (wb_csr_num),
    .wb_csr_wdata   (wb_csr_wdata),
    .wb_csr_wmask   (wb_csr_wmask),
    .csr_crmd       (csr_crmd),
    .csr_prmd       (csr_prmd),
    .csr_eentry     (csr_eentry),
    .csr_era        (csr_era),
    .csr_we         (csr_we),
    .csr_num        (csr_num),
    .csr_wdata      (csr_wdata),
    .csr_wmask      (csr_wmask),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .seq_ready_go   (seq_ready_go),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after the edge; outputs are sampled 1 ns after that.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid     = 1'b0;
    wb_ex        = 1'b0;
    wb_ertn      = 1'b0;
    wb_ecode     = '0;
    wb_esubcode  = '0;
    wb_badv_we   = 1'b0;
    wb_badv      = '0;
    wb_pc        = '0;
    wb_csr_we    = 1'b0;
    wb_csr_num   = '0;
    wb_csr_wdata = '0;
    wb_csr_wmask = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    csr_crmd = '0; csr_prmd = '0; csr_eentry = '0; csr_era = '0;
    repeat (2) cyc();
    #1;
    checks++;
    if (ctl !== 4'b0010) begin
      errors++; $display("FAIL reset_ctl: got %b exp %b", ctl, 4'b0010);
    end
    checks++;
    if (csr_we !== 1'b0) begin
      errors++; $display("FAIL reset_we: got %b exp %b", csr_we, 1'b0);
    end
    cyc();
    reset = 1'b0;
    cyc(); #1;
    checks++;
    if ({ctl, csr_we} !== 5'b00100) begin
      errors++; $display("FAIL post_reset: got %b exp %b", {ctl, csr_we}, 5'b00100);
    end
    $display("test_reset done, errors=%0d", errors);
  endtask

  task automatic test_passthrough();
    cyc();
    wb_valid = 1'b1; wb_csr_we = 1'b1; wb_csr_num = 14'h00C;
    wb_csr_wdata = 32'h1C00_0000; wb_csr_wmask = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (csr_bus !== {1'b1, 14'h00C, 32'h1C00_0000, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL pass_csrwr: got %h exp %h", csr_bus, {1'b1, 14'h00C, 32'h1C00_0000, 32'hFFFF_FFFF});
    end
    checks++;
    if (ctl !== 4'b0010) begin
      errors++; $display("FAIL pass_ctl: got %b exp %b", ctl, 4'b0010);
    end
    cyc();
    wb_csr_num = 14'h004; wb_csr_wdata = 32'h0000_1234; wb_csr_wmask = 32'h0000_1FFF;
    #1;
    checks++;
    if (csr_bus !== {1'b1, 14'h004, 32'h0000_1234, 32'h0000_1FFF}) begin
      errors++; $display("FAIL pass_xchg: got %h exp %h", csr_bus, {1'b1, 14'h004, 32'h0000_1234, 32'h0000_1FFF});
    end
    cyc();
    idle_inputs();
    #1;
    checks++;
    if (csr_we !== 1'b0) begin
      errors++; $display("FAIL pass_idle_we: got %b exp %b", csr_we, 1'b0);
    end
    $display("test_passthrough done, errors=%0d", errors);
  endtask

  task automatic test_syscall();
    cyc();
    wb_valid = 1'b1; wb_ex = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 9'h0;
    wb_pc = 32'h1C00_0100;
    wb_csr_we = 1'b1; wb_csr_num = 14'h006; wb_csr_wdata = 32'hDEAD_BEEF; wb_csr_wmask = 32'hFFFF_FFFF;
    csr_crmd = 32'h7; csr_eentry = 32'h1C00_8000; csr_era = 32'h0;
    #1;
    checks++;
    if ({ctl, csr_we} !== 5'b10000) begin
      errors++; $display("FAIL sys_t0: got %b exp %b", {ctl, csr_we}, 5'b10000);
    end
    cyc();
    idle_inputs();
    wb_pc = 32'hFFFF_0000; wb_ecode = 6'h3F;
    #1;
    checks++;
    if ({ctl, csr_bus} !== {4'b0001, 1'b1, 14'h001, 32'h7, 32'h7}) begin
      errors++; $display("FAIL sys_t1_prmd: got %h exp %h", {ctl, csr_bus}, {4'b0001, 1'b1, 14'h001, 32'h7, 32'h7});
    end
    cyc(); #1;
    checks++;
    if ({ctl, csr_bus} !== {4'b0001, 1'b1, 14'h000, 32'h0, 32'h7}) begin
      errors++; $display("FAIL sys_t2_crmd: got %h exp %h", {ctl, csr_bus}, {4'b0001, 1'b1, 14'h000, 32'h0, 32'h7});
    end
    cyc(); #1;
    checks++;
    if ({ctl, csr_bus} !== {4'b0001, 1'b1, 14'h005, 32'h000B_0000, 32'h7FFF_0000}) begin
      errors++; $display("FAIL sys_t3_estat: got %h exp %h", {ctl, csr_bus}, {4'b0001, 1'b1, 14'h005, 32'h000B_0000, 32'h7FFF_0000});
    end
    cyc(); #1;
    checks++;
    if ({ctl, csr_bus} !== {4'b0001, 1'b1, 14'h006, 32'h1C00_0100, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL sys_t4_era: got %h exp %h", {ctl, csr_bus}, {4'b0001, 1'b1, 14'h006, 32'h1C00_0100, 32'hFFFF_FFFF});
    end
    cyc(); #1;
    checks++;
    if ({ctl, csr_we, redirect_pc} !== {4'b0111, 1'b0, 32'h1C00_8000}) begin
      errors++; $display("FAIL sys_t5_redir: got %h exp %h", {ctl, csr_we, redirect_pc}, {4'b0111, 1'b0, 32'h1C00_8000});
    end
    cyc(); #1;
    checks++;
    if ({ctl, csr_we} !== 5'b00100) begin
      errors++; $display("FAIL sys_t6_idle: got %b exp %b", {ctl, csr_we}, 5'b00100);
    end
    $display("test_syscall done, errors=%0d", errors);
  endtask

  task automatic test_adef_badv();
    cyc();
    wb_valid = 1'b1; wb_ex = 1'b1; wb_ecode = 6'h08; wb_esubcode = 9'h0;
    wb_pc = 32'h1C00_0103; wb_badv_we = 1'b1; wb_badv = 32'h1C00_0103;
    csr_crmd = 32'h3; csr_eentry = 32'h1C00_8000;
    #1;
    checks++;
    if (ctl !== 4'b1000) begin
      errors++; $display("FAIL adef_t0: got %b exp %b", ctl, 4'b1000);
    end
    cyc();
    idle_inputs();
    #1;
    checks++;
    if (csr_bus !== {1'b1, 14'h001, 32'h3, 32'h7}) begin
      errors++; $display("FAIL adef_t1_prmd: got %h exp %h", csr_bus, {1'b1, 14'h001, 32'h3, 32'h7});
    end
    cyc(); cyc(); #1;
    checks++;
    if (csr_bus !== {1'b1, 14'h005, 32'h0008_0000, 32'h7FFF_0000}) begin
      errors++; $display("FAIL adef_t3_estat: got %h exp %h", csr_bus, {1'b1, 14'h005, 32'h0008_0000, 32'h7FFF_0000});
    end
    cyc(); #1;
    checks++;
    if (csr_bus !== {1'b1, 14'h006, 32'h1C00_0103, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL adef_t4_era: got %h exp %h", csr_bus, {1'b1, 14'h006, 32'h1C00_0103, 32'hFFFF_FFFF});
    end
    cyc(); #1;
    checks++;
    if ({ctl, csr_bus} !== {4'b0001, 1'b1, 14'h007, 32'h1C00_0103, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL adef_t5_badv: got %h exp %h", {ctl, csr_bus}, {4'b0001, 1'b1, 14'h007, 32'h1C00_0103, 32'hFFFF_FFFF});
    end
    cyc(); #1;
    checks++;
    if ({ctl, csr_we, redirect_pc} !== {4'b0111, 1'b0, 32'h1C00_8000}) begin
      errors++; $display("FAIL adef_t6_redir: got %h exp %h", {ctl, csr_we, redirect_pc}, {4'b0111, 1'b0, 32'h1C00_8000});
    end
    $display("test_adef_badv done, errors=%0d", errors);
  endtask

  task automatic test_ertn();
    cyc();
    wb_valid = 1'b1; wb_ertn = 1'b1; wb_pc = 32'h1C00_0200;
    csr_prmd = 32'h5; csr_era = 32'h1C00_0104; csr_eentry = 32'h1C00_8000;
    #1;
    checks++;
    if ({ctl, csr_we} !== 5'b10000) begin
      errors++; $display("FAIL ertn_t0: got %b exp %b", {ctl, csr_we}, 5'b10000);
    end
    cyc();
    idle_inputs();
    #1;
    checks++;
    if ({ctl, csr_bus} !== {4'b0001, 1'b1, 14'h000, 32'h5, 32'h7}) begin
      errors++; $display("FAIL ertn_t1_crmd: got %h exp %h", {ctl, csr_bus}, {4'b0001, 1'b1, 14'h000, 32'h5, 32'h7});
    end
    cyc(); #1;
    checks++;
    if ({ctl, csr_we, redirect_pc} !== {4'b0111, 1'b0, 32'h1C00_0104}) begin
      errors++; $display("FAIL ertn_t2_redir: got %h exp %h", {ctl, csr_we, redirect_pc}, {4'b0111, 1'b0, 32'h1C00_0104});
    end
    cyc(); #1;
    checks++;
    if (ctl !== 4'b0010) begin
      errors++; $display("FAIL ertn_t3_idle: got %b exp %b", ctl, 4'b0010);
    end
    $display("test_ertn done, errors=%0d", errors);
  endtask

  task automatic test_ex_and_ertn();
    cyc();
    wb_valid = 1'b1; wb_ex = 1'b1; wb_ertn = 1'b1;
    wb_ecode = 6'h0D; wb_esubcode = 9'h003; wb_pc = 32'h1C00_0300;
    csr_crmd = 32'h3; csr_era = 32'h1C00_0104; csr_eentry = 32'h1C00_9000;
    cyc();
    idle_inputs();
    #1;
    checks++;
    if (csr_bus !== {1'b1, 14'h001, 32'h3, 32'h7}) begin
      errors++; $display("FAIL both_t1_prmd: got %h exp %h", csr_bus, {1'b1, 14'h001, 32'h3, 32'h7});
    end
    cyc(); cyc(); #1;
    checks++;
    if (csr_bus !== {1'b1, 14'h005, 32'h00CD_0000, 32'h7FFF_0000}) begin
      errors++; $display("FAIL both_t3_estat: got %h exp %h", csr_bus, {1'b1, 14'h005, 32'h00CD_0000, 32'h7FFF_0000});
    end
    cyc(); cyc(); #1;
    checks++;
    if ({ctl, redirect_pc} !== {4'b0111, 32'h1C00_9000}) begin
      errors++; $display("FAIL both_t5_redir: got %h exp %h", {ctl, redirect_pc}, {4'b0111, 32'h1C00_9000});
    end
    $display("test_ex_and_ertn done, errors=%0d", errors);
  endtask

  task automatic test_back_to_back();
    cyc();
    wb_valid = 1'b1; wb_ex = 1'b1; wb_ecode = 6'h0B; wb_pc = 32'h1C00_0400;
    csr_crmd = 32'h1; csr_eentry = 32'h1C00_8000;
    cyc();
    wb_pc = 32'h1C00_0500;
    #1;
    checks++;
    if ({ctl, csr_num} !== {4'b0001, 14'h001}) begin
      errors++; $display("FAIL b2b_t1: got %h exp %h", {ctl, csr_num}, {4'b0001, 14'h001});
    end
    cyc(); cyc(); cyc(); #1;
    checks++;
    if (csr_bus !== {1'b1, 14'h006, 32'h1C00_0400, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL b2b_t4_era: got %h exp %h", csr_bus, {1'b1, 14'h006, 32'h1C00_0400, 32'hFFFF_FFFF});
    end
    cyc(); #1;
    checks++;
    if (ctl !== 4'b0111) begin
      errors++; $display("FAIL b2b_t5_redir_no_flush: got %b exp %b", ctl, 4'b0111);
    end
    cyc(); #1;
    checks++;
    if ({ctl, csr_we} !== 5'b10000) begin
      errors++; $display("FAIL b2b_t6_retrigger: got %b exp %b", {ctl, csr_we}, 5'b10000);
    end
    cyc();
    idle_inputs();
    #1;
    checks++;
    if (csr_bus !== {1'b1, 14'h001, 32'h1, 32'h7}) begin
      errors++; $display("FAIL b2b_t7_prmd: got %h exp %h", csr_bus, {1'b1, 14'h001, 32'h1, 32'h7});
    end
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    $display("test_back_to_back done, errors=%0d", errors);
  endtask

  task automatic test_reset_mid();
    cyc();
    wb_valid = 1'b1; wb_ex = 1'b1; wb_ecode = 6'h0B; wb_pc = 32'h1C00_0600;
    csr_crmd = 32'h7; csr_prmd = 32'h2; csr_era = 32'h1C00_0700; csr_eentry = 32'h1C00_8000;
    cyc();
    idle_inputs();
    cyc(); cyc(); #1;
    checks++;
    if (csr_num !== 14'h005) begin
      errors++; $display("FAIL rst_mid_in_estat: got %h exp %h", csr_num, 14'h005);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    checks++;
    if ({ctl, csr_we} !== 5'b00100) begin
      errors++; $display("FAIL rst_mid_idle: got %b exp %b", {ctl, csr_we}, 5'b00100);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      checks++;
      if ({redirect_valid, csr_we, busy} !== 3'b000) begin
        errors++; $display("FAIL rst_mid_quiet%0d: got %b exp %b", i, {redirect_valid, csr_we, busy}, 3'b000);
      end
    end
    cyc();
    wb_valid = 1'b1; wb_ertn = 1'b1;
    #1;
    checks++;
    if (ctl !== 4'b1000) begin
      errors++; $display("FAIL rst_mid_new_trigger: got %b exp %b", ctl, 4'b1000);
    end
    cyc();
    idle_inputs();
    #1;
    checks++;
    if (csr_bus !== {1'b1, 14'h000, 32'h2, 32'h7}) begin
      errors++; $display("FAIL rst_mid_ertn_crmd: got %h exp %h", csr_bus, {1'b1, 14'h000, 32'h2, 32'h7});
    end
    cyc(); #1;
    checks++;
    if ({ctl, redirect_pc} !== {4'b0111, 32'h1C00_0700}) begin
      errors++; $display("FAIL rst_mid_ertn_redir: got %h exp %h", {ctl, redirect_pc}, {4'b0111, 32'h1C00_0700});
    end
    $display("test_reset_mid done, errors=%0d", errors);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_passthrough();
    test_syscall();
    test_adef_badv();
    test_ertn();
    test_ex_and_ertn();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
